// File: rtl/udp_echo_app_stats_logger.sv
// Per-interval packet/byte counter for the UDP echo app; writes one
// {pkt_cnt, byte_cnt} entry per interval into a circular log RAM.
module udp_echo_app_stats_logger #(
  parameter int STATS_DEPTH_LOG2 = 7,
  parameter int INTERVAL_CYCLES  = 250000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        log_en,
  input  logic                        log_clear,
  input  logic                        pkt_evt_val,
  input  logic [15:0]                 pkt_evt_bytes,
  input  logic [STATS_DEPTH_LOG2-1:0] log_rd_req_addr,
  output logic [63:0]                 log_rd_resp_data,
  output logic [STATS_DEPTH_LOG2-1:0] curr_wr_addr,
  output logic                        has_wrapped
);

  localparam int                  DEPTH      = 2 ** STATS_DEPTH_LOG2;
  localparam int                  TIMER_W    = $clog2(INTERVAL_CYCLES);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(INTERVAL_CYCLES - 1);
  localparam logic [31:0]         CNT_MAX    = 32'hFFFF_FFFF;

  logic [63:0]        stats_ram [DEPTH];
  logic [TIMER_W-1:0] timer;
  logic [31:0]        pkt_cnt, byte_cnt;
  logic [31:0]        pkt_cnt_nxt, byte_cnt_nxt;
  logic [32:0]        byte_sum;
  logic               count_evt, boundary, ram_we;

  // Primed counters include this cycle's event so a boundary-cycle packet
  // lands in the interval that is closing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pkt_cnt_nxt  = pkt_cnt;
    byte_cnt_nxt = byte_cnt;
    count_evt    = log_en & pkt_evt_val;
    boundary     = log_en & (timer == TIMER_LAST);
    ram_we       = boundary & ~log_clear;
    byte_sum     = {1'b0, byte_cnt} + {17'd0, pkt_evt_bytes};
    if (count_evt) begin
      pkt_cnt_nxt  = (pkt_cnt == CNT_MAX) ? CNT_MAX : pkt_cnt + 32'd1;
      byte_cnt_nxt = byte_sum[32] ? CNT_MAX : byte_sum[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      curr_wr_addr <= '0;
      has_wrapped  <= 1'b0;
    end else if (log_clear) begin
      timer        <= '0;
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      curr_wr_addr <= '0;
      has_wrapped  <= 1'b0;
    end else if (boundary) begin
      timer        <= '0;
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      curr_wr_addr <= curr_wr_addr + 1'b1;
      if (curr_wr_addr == '1) has_wrapped <= 1'b1;
    end else if (log_en) begin
      timer    <= timer + TIMER_W'(1);
      pkt_cnt  <= pkt_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; the reader
  // bounds its reads with curr_wr_addr/has_wrapped instead.
  always_ff @(posedge clk) begin
    if (ram_we) stats_ram[curr_wr_addr] <= {pkt_cnt_nxt, byte_cnt_nxt};
  end

  // Separate read register gives read-first behaviour on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) log_rd_resp_data <= '0;
    else        log_rd_resp_data <= stats_ram[log_rd_req_addr];
  end

endmodule

// File: tb/tb_udp_echo_app_stats_logger.sv
// Directed bench: a 4-entry/8-cycle logger driven from a vector table plus
// hand sequences, and a 70000-cycle instance for byte counter saturation.
module tb_udp_echo_app_stats_logger;

  logic        clk, rst_n;
  logic        log_en, log_clear, pkt_evt_val;
  logic [15:0] pkt_evt_bytes;
  logic [1:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_addr;
  logic        wrapped;

  logic        b_en, b_evt;
  logic [15:0] b_bytes;
  logic [1:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_wr_addr;
  logic        b_wrapped;

  int n_tests = 0;
  int n_fail  = 0;

  udp_echo_app_stats_logger #(.STATS_DEPTH_LOG2(2), .INTERVAL_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .log_en(log_en), .log_clear(log_clear),
    .pkt_evt_val(pkt_evt_val), .pkt_evt_bytes(pkt_evt_bytes),
    .log_rd_req_addr(rd_addr), .log_rd_resp_data(rd_data),
    .curr_wr_addr(wr_addr), .has_wrapped(wrapped)
  );

  udp_echo_app_stats_logger #(.STATS_DEPTH_LOG2(2), .INTERVAL_CYCLES(70000)) dut_big (
    .clk(clk), .rst_n(rst_n), .log_en(b_en), .log_clear(1'b0),
    .pkt_evt_val(b_evt), .pkt_evt_bytes(b_bytes),
    .log_rd_req_addr(b_rd_addr), .log_rd_resp_data(b_rd_data),
    .curr_wr_addr(b_wr_addr), .has_wrapped(b_wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, clr, evt;
    logic [15:0] bytes;
    logic [1:0]  rd;
    logic [1:0]  exp_wr;
    logic        exp_wrap;
    logic        chk;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NV = 41;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic evt,
                       input logic [15:0] bytes, input logic [1:0] rd);
    log_en        = en;
    log_clear     = clr;
    pkt_evt_val   = evt;
    pkt_evt_bytes = bytes;
    rd_addr       = rd;
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
    b_en = 1'b0; b_evt = 1'b0; b_bytes = 16'd0; b_rd_addr = 2'd0;

    // Intervals 0..4 back to back: entry contents, pointer walk, wrap, read-first.
    for (int i = 0; i < NV; i++)
      vecs[i] = '{en: 1'b1, clr: 1'b0, evt: 1'b0, bytes: 16'd0, rd: 2'd0,
                  exp_wr: 2'(((i + 1) / 8) % 4), exp_wrap: ((i + 1) >= 32),
                  chk: 1'b0, exp_data: 64'd0};
    for (int i = 0; i < 3; i++) begin vecs[i].evt = 1'b1; vecs[i].bytes = 16'd100; end
    vecs[8].evt  = 1'b1; vecs[8].bytes  = 16'd10;
    vecs[8].chk  = 1'b1; vecs[8].exp_data  = {32'd3, 32'd300};
    vecs[15].evt = 1'b1; vecs[15].bytes = 16'd40;
    vecs[16].rd  = 2'd1; vecs[16].chk = 1'b1; vecs[16].exp_data = {32'd2, 32'd50};
    vecs[24].rd  = 2'd2; vecs[24].chk = 1'b1; vecs[24].exp_data = 64'd0;
    vecs[32].rd  = 2'd3; vecs[32].chk = 1'b1; vecs[32].exp_data = 64'd0;
    vecs[32].evt = 1'b1; vecs[32].bytes = 16'd7;
    vecs[39].chk = 1'b1; vecs[39].exp_data = {32'd3, 32'd300};
    vecs[40].chk = 1'b1; vecs[40].exp_data = {32'd1, 32'd7};

    repeat (2) @(posedge clk);
    #1;
    check("reset_data", rd_data, 64'd0);
    check("reset_wr_addr", wr_addr, 64'd0);
    check("reset_wrapped", wrapped, 64'd0);
    check("big_reset_wr_addr", b_wr_addr, 64'd0);
    check("big_reset_data", b_rd_data, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].evt, vecs[i].bytes, vecs[i].rd);
      tick();
      check($sformatf("vec%0d_wr_addr", i), wr_addr, vecs[i].exp_wr);
      check($sformatf("vec%0d_wrapped", i), wrapped, vecs[i].exp_wrap);
      if (vecs[i].chk) check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
    end

    // log_clear on a boundary cycle (timer is 1 here): no write, pointer and wrap cleared.
    repeat (6) begin drive(1'b1, 1'b0, 1'b0, 16'd0, 2'd0); tick(); end
    check("clr_pre_wr_addr", wr_addr, 64'd1);
    drive(1'b1, 1'b1, 1'b1, 16'd40, 2'd0);
    tick();
    check("clr_wr_addr", wr_addr, 64'd0);
    check("clr_wrapped", wrapped, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 2'd1);
    tick();
    check("clr_no_write_entry1", rd_data, {32'd2, 32'd50});

    // log_en low mid-interval: events ignored, timer holds and resumes.
    repeat (3) begin drive(1'b1, 1'b0, 1'b1, 16'd5, 2'd0); tick(); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'd99, 2'd0);
      tick();
      if (i == 19) check("hold_wr_addr", wr_addr, 64'd0);
    end
    repeat (4) begin drive(1'b1, 1'b0, 1'b0, 16'd0, 2'd0); tick(); end
    check("hold_pre_boundary", wr_addr, 64'd0);
    tick();
    check("hold_boundary", wr_addr, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
    tick();
    check("hold_entry0", rd_data, {32'd3, 32'd15});

    // Async reset mid-interval: outputs drop at once, RAM untouched.
    repeat (3) begin drive(1'b1, 1'b0, 1'b1, 16'd9, 2'd0); tick(); end
    check("prerst_data", rd_data, {32'd3, 32'd15});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", rd_data, 64'd0);
    check("async_rst_wr_addr", wr_addr, 64'd0);
    check("async_rst_wrapped", wrapped, 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 2'd1);
    tick();
    check("rst_no_write_entry1", rd_data, {32'd2, 32'd50});
    drive(1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
    tick();
    check("rst_entry0_kept", rd_data, {32'd3, 32'd15});

    // 65538 max-size packets: byte count saturates, packet count does not.
    b_en = 1'b1; b_evt = 1'b1; b_bytes = 16'hFFFF;
    repeat (65538) tick();
    b_evt = 1'b0;
    for (n = 0; n < 80000 && b_wr_addr != 2'd1; n++) tick();
    check("big_boundary_reached", b_wr_addr, 64'd1);
    check("big_boundary_cycles", 64'(n), 64'd4462);
    b_en = 1'b0;
    tick();
    check("big_saturated_entry", b_rd_data, {32'h0001_0002, 32'hFFFF_FFFF});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
